// File: rtl/delta_sigma_pkg.sv
// -----------------------------------------------------------------------------
// delta_sigma_pkg
// Purpose : Shared definitions for the delta-sigma destreamer slice.
//           Holds the default sample width, the derived oversampling ratio
//           and the controller state enumeration.
// Contents: DATA_WIDTH_DEFAULT - default sample width in bits
//           OSR_DEFAULT        - clocks per sample for the default width
//           osr_for()          - oversampling ratio for an arbitrary width
//           state_t            - IDLE / FETCH / LOAD / RUN
// -----------------------------------------------------------------------------
package delta_sigma_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    // One frame is a full sweep of a DATA_WIDTH-bit counter.
    function automatic int osr_for(input int width);
        return 2 ** width;
    endfunction

    localparam int OSR_DEFAULT = 2 ** DATA_WIDTH_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        RUN   = 2'd3
    } state_t;

endpackage

// File: rtl/first_order_modulator.sv
// -----------------------------------------------------------------------------
// first_order_modulator
// Purpose : First-order delta-sigma modulator. Each enabled clock adds the
//           sample into a DATA_WIDTH-bit accumulator; the carry out of that
//           addition is the output bit, registered for one cycle of latency.
//           Over 2**DATA_WIDTH enabled clocks exactly 'sample' carries occur,
//           whatever residue the accumulator started with.
// Ports   : clk    - rising-edge clock
//           rst    - synchronous active-high reset
//           clear  - zero the accumulator and force the output bit low
//           enable - perform one accumulate step this clock
//           sample - value being modulated
//           bitOut - registered carry (serial bitstream)
// -----------------------------------------------------------------------------
module first_order_modulator
    import delta_sigma_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic                  bitOut
);

    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic                  bit_q;
    logic                  bit_d;
    logic [DATA_WIDTH:0]   sum;

    // Sum is one bit wider than the accumulator so the MSB is the carry.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, sample};
        acc_d = acc_q;
        bit_d = 1'b0;
        if (clear) begin
            acc_d = '0;
        end else if (enable) begin
            acc_d = sum[DATA_WIDTH-1:0];
            bit_d = sum[DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            bit_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            bit_q <= bit_d;
        end
    end

    assign bitOut = bit_q;

endmodule

// File: rtl/binary_destreamer.sv
// -----------------------------------------------------------------------------
// binary_destreamer
// Purpose : Pulls samples from an upstream FIFO and plays each one for a
//           frame of 2**DATA_WIDTH clocks through a first-order delta-sigma
//           modulator. The next sample is prefetched near the end of a frame
//           so consecutive frames run without gap cycles; if no sample is
//           available the current one is repeated and underflow pulses.
// Ports   : clk            - rising-edge clock
//           rst            - synchronous active-high reset
//           dacEnable      - run request; dropping it stops at a frame boundary
//           sampleData     - FIFO read data, valid one cycle after the strobe
//           fifoEmpty      - FIFO empty flag
//           fifoReadEnable - one-cycle FIFO read strobe (registered)
//           dacOutput      - serial bitstream (registered)
//           busy           - high while running (registered)
//           underflow      - one-cycle pulse when a frame repeats a sample
// -----------------------------------------------------------------------------
module binary_destreamer
    import delta_sigma_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dacEnable,
    input  logic [DATA_WIDTH-1:0] sampleData,
    input  logic                  fifoEmpty,
    output logic                  fifoReadEnable,
    output logic                  dacOutput,
    output logic                  busy,
    output logic                  underflow
);

    localparam int OSR = osr_for(DATA_WIDTH);

    // The strobe is registered, so deciding at OSR-3 puts it on the bus at
    // OSR-2 and the data arrives at OSR-1, just in time for the wrap.
    localparam logic [DATA_WIDTH-1:0] COUNT_PREFETCH = DATA_WIDTH'(OSR - 3);
    localparam logic [DATA_WIDTH-1:0] COUNT_LAST     = DATA_WIDTH'(OSR - 1);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] frameCount_q;
    logic [DATA_WIDTH-1:0] frameCount_d;
    logic [DATA_WIDTH-1:0] curSample_q;
    logic [DATA_WIDTH-1:0] curSample_d;
    logic [DATA_WIDTH-1:0] nextSample;
    logic                  nextValid_q;
    logic                  nextValid_d;
    logic                  fifoReadEnable_q;
    logic                  fifoReadEnable_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic                  modClear;
    logic                  modEnable;

    // The prefetched word is on sampleData exactly during the OSR-1 cycle,
    // which is also the wrap cycle, so it is forwarded straight into
    // curSample rather than parked in a separate holding register.
    // nextValid marks that a prefetch strobe was issued this frame; once
    // set, the sample is committed and plays regardless of dacEnable.
    assign nextSample = sampleData;

    // Next-state and registered-output logic for the controller.
    always_comb begin
        state_d          = state_q;
        frameCount_d     = frameCount_q;
        curSample_d      = curSample_q;
        nextValid_d      = nextValid_q;
        fifoReadEnable_d = 1'b0;
        underflow_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (dacEnable && !fifoEmpty) begin
                    fifoReadEnable_d = 1'b1;
                    state_d          = FETCH;
                end
            end

            FETCH: begin
                state_d = LOAD;
            end

            LOAD: begin
                curSample_d  = sampleData;
                frameCount_d = '0;
                nextValid_d  = 1'b0;
                state_d      = RUN;
            end

            RUN: begin
                frameCount_d = frameCount_q + 1'b1;

                if (frameCount_q == COUNT_PREFETCH && dacEnable && !fifoEmpty) begin
                    fifoReadEnable_d = 1'b1;
                    nextValid_d      = 1'b1;
                end

                if (frameCount_q == COUNT_LAST) begin
                    if (nextValid_q) begin
                        curSample_d = nextSample;
                        nextValid_d = 1'b0;
                    end else if (dacEnable) begin
                        underflow_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            frameCount_q     <= '0;
            curSample_q      <= '0;
            nextValid_q      <= 1'b0;
            fifoReadEnable_q <= 1'b0;
            busy_q           <= 1'b0;
            underflow_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            frameCount_q     <= frameCount_d;
            curSample_q      <= curSample_d;
            nextValid_q      <= nextValid_d;
            fifoReadEnable_q <= fifoReadEnable_d;
            busy_q           <= busy_d;
            underflow_q      <= underflow_d;
        end
    end

    // The accumulator only runs in RUN and is held at zero everywhere else,
    // so every start from IDLE begins from a clean residue.
    assign modEnable = (state_q == RUN);
    assign modClear  = (state_q != RUN);

    first_order_modulator #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_modulator (
        .clk   (clk),
        .rst   (rst),
        .clear (modClear),
        .enable(modEnable),
        .sample(curSample_q),
        .bitOut(dacOutput)
    );

    assign fifoReadEnable = fifoReadEnable_q;
    assign busy           = busy_q;
    assign underflow      = underflow_q;

endmodule

// File: tb/tb_binary_destreamer.sv
// -----------------------------------------------------------------------------
// tb_binary_destreamer
// Purpose : Self-checking bench for binary_destreamer. A queue models the
//           upstream FIFO; a frame-level reference model predicts which
//           sample each frame plays, where underflow pulses and how many
//           reads happen, and the observed bitstream is compared per frame.
// -----------------------------------------------------------------------------
module tb_binary_destreamer;

    localparam int DW  = 8;
    localparam int OSR = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dacEnable = 1'b0;
    logic [DW-1:0] sampleData = '0;
    logic          fifoEmpty = 1'b1;
    logic          fifoReadEnable;
    logic          dacOutput;
    logic          busy;
    logic          underflow;

    int testsRun    = 0;
    int testsFailed = 0;

    // Upstream FIFO model and its read accounting.
    logic [DW-1:0] fifoQ[$];
    int readCount = 0;
    int readBad   = 0;

    // Observations from one run.
    int obsOnes[9];
    int obsUnder[9];
    int obsStray;
    int obsBusyMiss;
    int strobeGap;
    int readsDuring;
    bit timedOut;

    // Reference model predictions.
    int expOnes[9];
    int expUnder[9];
    int expFrames;
    int expReads;

    binary_destreamer #(.DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .dacEnable     (dacEnable),
        .sampleData    (sampleData),
        .fifoEmpty     (fifoEmpty),
        .fifoReadEnable(fifoReadEnable),
        .dacOutput     (dacOutput),
        .busy          (busy),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // FIFO: data appears one cycle after the strobe; empty follows the queue.
    always @(posedge clk) begin
        if (fifoReadEnable) begin
            readCount <= readCount + 1;
            if (fifoEmpty) readBad <= readBad + 1;
            if (fifoQ.size() > 0) sampleData <= fifoQ.pop_front();
        end
        fifoEmpty <= (fifoQ.size() == 0);
    end

    task automatic doReset();
        rst       = 1'b1;
        dacEnable = 1'b0;
        fifoQ.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Frame-level model: a frame plays one sample for OSR clocks. If enable
    // is high at the prefetch point and the FIFO has data, the next frame
    // plays the next item; otherwise an enabled wrap repeats the sample with
    // underflow, and a disabled wrap stops. dacEnable is high for run-relative
    // cycle c exactly when dropAt < 0 or c < dropAt.
    task automatic modelRun(input int items[$], input int nFrames, input int dropAt);
        int nextIdx;
        int playing;
        int pre;
        int wrap;
        for (int i = 0; i < 9; i++) begin
            expOnes[i]  = 0;
            expUnder[i] = 0;
        end
        expFrames = 0;
        expReads  = 0;
        if (items.size() == 0) return;
        expReads = 1;
        nextIdx  = 1;
        playing  = items[0];
        for (int f = 0; f < nFrames; f++) begin
            expOnes[f] = playing;
            expFrames  = f + 1;
            pre  = OSR * f + OSR - 3;
            wrap = OSR * f + OSR - 1;
            if ((dropAt < 0 || pre < dropAt) && nextIdx < items.size()) begin
                playing = items[nextIdx];
                nextIdx++;
                expReads++;
            end else if (dropAt < 0 || wrap < dropAt) begin
                expUnder[f + 1] = 1;
            end else begin
                break;
            end
        end
    endtask

    // Preloads the FIFO, raises dacEnable and records per-frame behaviour.
    // Run-relative cycle 0 is the first negedge at which busy is seen high.
    task automatic measureRun(input int items[$], input int nFrames, input int dropAt);
        int r0;
        int idx;
        int strobeIdx;
        foreach (items[i]) fifoQ.push_back(items[i][DW-1:0]);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            obsOnes[i]  = 0;
            obsUnder[i] = 0;
        end
        obsStray    = 0;
        obsBusyMiss = 0;
        r0          = readCount;
        dacEnable   = 1'b1;
        timedOut    = 1'b1;
        strobeIdx   = -1;
        for (idx = 0; idx < 20; idx++) begin
            @(negedge clk);
            if (fifoReadEnable && strobeIdx < 0) strobeIdx = idx;
            if (busy) begin
                timedOut = 1'b0;
                break;
            end
        end
        strobeGap = idx - strobeIdx;
        if (!timedOut) begin
            for (int c = 0; c <= OSR * nFrames; c++) begin
                if (c > 0) begin
                    @(negedge clk);
                    obsOnes[(c - 1) / OSR] += int'(dacOutput);
                end
                if (underflow) begin
                    if (c > 0 && c % OSR == 0) obsUnder[c / OSR]++;
                    else obsStray++;
                end
                if (c < OSR * expFrames && !busy) obsBusyMiss++;
                if (expFrames < nFrames && c >= OSR * expFrames && busy) obsBusyMiss++;
                if (c == dropAt) dacEnable = 1'b0;
            end
        end
        readsDuring = readCount - r0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        testsRun++;
        if (dacOutput !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dacOutput got %b want 0", dacOutput);
        end
        testsRun++;
        if (busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy got %b want 0", busy);
        end
        testsRun++;
        if (underflow !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_underflow got %b want 0", underflow);
        end
        testsRun++;
        if (fifoReadEnable !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_fifoReadEnable got %b want 0", fifoReadEnable);
        end
        doReset();
    endtask

    task automatic test_single_sample();
        int items[$];
        items.push_back(8'h40);
        modelRun(items, 1, -1);
        measureRun(items, 1, -1);
        testsRun++;
        if (timedOut !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL single_start_timeout got busy=%b want busy=1 within 20 cycles", busy);
        end
        testsRun++;
        if (strobeGap !== 2) begin
            testsFailed++;
            $display("[TB] FAIL single_strobe_to_run got %0d want 2", strobeGap);
        end
        testsRun++;
        if (obsOnes[0] !== expOnes[0]) begin
            testsFailed++;
            $display("[TB] FAIL single_ones got %0d want %0d", obsOnes[0], expOnes[0]);
        end
        testsRun++;
        if (obsBusyMiss !== 0) begin
            testsFailed++;
            $display("[TB] FAIL single_busy got %0d bad cycles want 0", obsBusyMiss);
        end
        testsRun++;
        if (readsDuring !== expReads) begin
            testsFailed++;
            $display("[TB] FAIL single_reads got %0d want %0d", readsDuring, expReads);
        end
        doReset();
    endtask

    task automatic test_back_to_back();
        int items[$];
        items.push_back(8'h00);
        items.push_back(8'hFF);
        items.push_back(8'h80);
        modelRun(items, 4, 2 * OSR + 10);
        measureRun(items, 4, 2 * OSR + 10);
        testsRun++;
        if (timedOut !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_start_timeout got busy=%b want 1", busy);
        end
        for (int f = 0; f < 4; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL b2b_ones frame %0d got %0d want %0d", f, obsOnes[f], expOnes[f]);
            end
            testsRun++;
            if (obsUnder[f] !== expUnder[f]) begin
                testsFailed++;
                $display("[TB] FAIL b2b_underflow frame %0d got %0d want %0d", f, obsUnder[f], expUnder[f]);
            end
        end
        testsRun++;
        if (obsBusyMiss !== 0 || obsStray !== 0) begin
            testsFailed++;
            $display("[TB] FAIL b2b_gaps got busy_bad=%0d stray_uf=%0d want 0/0", obsBusyMiss, obsStray);
        end
        doReset();
    endtask

    task automatic test_random_stream();
        int items[$];
        int dropAt;
        for (int i = 0; i < 5; i++) items.push_back(int'($urandom_range(0, 255)));
        dropAt = int'($urandom_range(3 * OSR, 4 * OSR - 1));
        modelRun(items, 6, dropAt);
        measureRun(items, 6, dropAt);
        testsRun++;
        if (timedOut !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rand_start_timeout got busy=%b want 1", busy);
        end
        for (int f = 0; f < 6; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL rand_ones frame %0d drop %0d got %0d want %0d", f, dropAt, obsOnes[f], expOnes[f]);
            end
        end
        testsRun++;
        if (readsDuring !== expReads) begin
            testsFailed++;
            $display("[TB] FAIL rand_reads drop %0d got %0d want %0d", dropAt, readsDuring, expReads);
        end
        testsRun++;
        if (obsBusyMiss !== 0 || obsStray !== 0) begin
            testsFailed++;
            $display("[TB] FAIL rand_busy got busy_bad=%0d stray_uf=%0d want 0/0", obsBusyMiss, obsStray);
        end
        doReset();
    endtask

    task automatic test_underflow();
        int items[$];
        int bad0;
        bad0 = readBad;
        items.push_back(8'h10);
        modelRun(items, 3, -1);
        measureRun(items, 3, -1);
        for (int f = 0; f < 3; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL uf_ones frame %0d got %0d want %0d", f, obsOnes[f], expOnes[f]);
            end
        end
        for (int f = 1; f <= 3; f++) begin
            testsRun++;
            if (obsUnder[f] !== expUnder[f]) begin
                testsFailed++;
                $display("[TB] FAIL uf_pulse frame %0d got %0d want %0d", f, obsUnder[f], expUnder[f]);
            end
        end
        testsRun++;
        if (obsStray !== 0) begin
            testsFailed++;
            $display("[TB] FAIL uf_stray got %0d want 0", obsStray);
        end
        testsRun++;
        if (readBad - bad0 !== 0 || readsDuring !== expReads) begin
            testsFailed++;
            $display("[TB] FAIL uf_reads got empty_reads=%0d reads=%0d want 0/%0d", readBad - bad0, readsDuring, expReads);
        end
        doReset();
    endtask

    task automatic test_disable_mid_frame();
        int items[$];
        items.push_back(8'h30);
        items.push_back(8'h50);
        modelRun(items, 2, 10);
        measureRun(items, 2, 10);
        for (int f = 0; f < 2; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL dis_ones frame %0d got %0d want %0d", f, obsOnes[f], expOnes[f]);
            end
        end
        testsRun++;
        if (readsDuring !== expReads) begin
            testsFailed++;
            $display("[TB] FAIL dis_reads got %0d want %0d", readsDuring, expReads);
        end
        testsRun++;
        if (obsBusyMiss !== 0 || busy !== 1'b0 || dacOutput !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL dis_idle got busy_bad=%0d busy=%b dac=%b want 0/0/0", obsBusyMiss, busy, dacOutput);
        end
        doReset();
    endtask

    task automatic test_disable_after_prefetch();
        int items[$];
        items.push_back(8'h30);
        items.push_back(8'h50);
        items.push_back(8'h70);
        modelRun(items, 3, OSR - 1);
        measureRun(items, 3, OSR - 1);
        for (int f = 0; f < 3; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL pre_ones frame %0d got %0d want %0d", f, obsOnes[f], expOnes[f]);
            end
        end
        testsRun++;
        if (readsDuring !== expReads) begin
            testsFailed++;
            $display("[TB] FAIL pre_reads got %0d want %0d", readsDuring, expReads);
        end
        testsRun++;
        if (obsBusyMiss !== 0 || obsStray !== 0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL pre_idle got busy_bad=%0d stray_uf=%0d busy=%b want 0/0/0", obsBusyMiss, obsStray, busy);
        end
        doReset();
    endtask

    task automatic test_reset_mid_frame();
        int items[$];
        int startOk;
        int r0;
        items.push_back(int'($urandom_range(0, 255)));
        items.push_back(int'($urandom_range(0, 255)));
        foreach (items[i]) fifoQ.push_back(items[i][DW-1:0]);
        repeat (2) @(negedge clk);
        dacEnable = 1'b1;
        startOk   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) begin
                startOk = 1;
                break;
            end
        end
        testsRun++;
        if (startOk !== 1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_start_timeout got busy=%b want 1", busy);
        end
        repeat (100) @(negedge clk);
        rst = 1'b1;
        r0  = readCount;
        @(negedge clk);
        testsRun++;
        if ({busy, dacOutput, underflow, fifoReadEnable} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_outputs got busy=%b dac=%b uf=%b rd=%b want all 0",
                     busy, dacOutput, underflow, fifoReadEnable);
        end
        repeat (3) @(negedge clk);
        testsRun++;
        if (readCount - r0 !== 0 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_quiet got reads=%0d busy=%b want 0/0", readCount - r0, busy);
        end
        doReset();
        items.delete();
        items.push_back(int'($urandom_range(0, 255)));
        items.push_back(int'($urandom_range(0, 255)));
        modelRun(items, 3, OSR + 10);
        measureRun(items, 3, OSR + 10);
        for (int f = 0; f < 3; f++) begin
            testsRun++;
            if (obsOnes[f] !== expOnes[f]) begin
                testsFailed++;
                $display("[TB] FAIL rstmid_restart_ones frame %0d got %0d want %0d", f, obsOnes[f], expOnes[f]);
            end
        end
        doReset();
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_random_stream();
        test_underflow();
        test_disable_mid_frame();
        test_disable_after_prefetch();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
